gpio_cfg_serializer: RTL

//  Management-side loader for the user-area digital GPIO pad configuration chain.

---
 rtl/gpio_cfg_serializer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gpio_cfg_serializer.sv
// gpio_cfg_serializer
//   Loads the user-area GPIO pad configuration chain from the management side.
//   One CFG_BITS-wide word is read per digital pad from a config register
//   file. The words are shifted out MSB first, starting with the last pad, into
//   the daisy-chained GPIO control blocks. A final load strobe makes every chain
//   register take effect at the same time.
//
// Ports
//   wb_clk_i         in   system clock, all logic on the rising edge
//   wb_rst_i         in   synchronous active-high reset
//   start            in   single-cycle transfer request (honoured only when idle)
//   abort            in   cancels a transfer in progress
//   busy             out  high while a transfer is in progress
//   done             out  single-cycle pulse once the load strobe has finished
//   cfg_rd           out  read strobe to the config register file
//   cfg_addr         out  pad index being read
//   cfg_data         in   word for cfg_addr, valid the cycle after cfg_rd
//   serial_clock     out  chain shift clock
//   serial_data_out  out  chain data, MSB of each word first
//   serial_load      out  chain load strobe
module gpio_cfg_serializer #(
  parameter int NUM_PADS = 27,
  parameter int CFG_BITS = 13,
  parameter int DIV      = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_rd,
  output logic [$clog2(NUM_PADS)-1:0] cfg_addr,
  input  logic [CFG_BITS-1:0]         cfg_data,
  output logic                        serial_clock,
  output logic                        serial_data_out,
  output logic                        serial_load
);

  localparam int AW = $clog2(NUM_PADS);
  localparam int BW = $clog2(CFG_BITS + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [AW-1:0]       addr_d;
  logic [BW-1:0]       bit_cnt, bit_cnt_d;
  logic [DW-1:0]       div_cnt, div_cnt_d;
  logic [CFG_BITS-1:0] shreg, shreg_d;
  logic                div_last;

  assign div_last = (div_cnt == DW'(DIV - 1));

  // Next-state logic. The divider counter times the DIV-cycle phases
  // (SHIFT_LO, SHIFT_HI, LOAD); the bit counter tracks bits sent of the
  // current word. abort overrides whatever transition was chosen.
  always_comb begin
    state_d   = state;
    addr_d    = cfg_addr;
    bit_cnt_d = bit_cnt;
    div_cnt_d = div_cnt;
    shreg_d   = shreg;

    case (state)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          addr_d    = AW'(NUM_PADS - 1);
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end

      FETCH: begin
        state_d = LATCH;
      end

      LATCH: begin
        shreg_d   = cfg_data;
        div_cnt_d = '0;
        state_d   = SHIFT_LO;
      end

      SHIFT_LO: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end

      SHIFT_HI: begin
        if (div_last) begin
          div_cnt_d = '0;
          shreg_d   = shreg << 1;
          bit_cnt_d = bit_cnt + BW'(1);
          if (bit_cnt_d < BW'(CFG_BITS)) begin
            state_d = SHIFT_LO;
          end else if (cfg_addr != '0) begin
            // Next (lower) pad; the address stops at zero and never wraps.
            addr_d    = cfg_addr - AW'(1);
            bit_cnt_d = '0;
            state_d   = FETCH;
          end else begin
            state_d = LOAD;
          end
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end

      LOAD: begin
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt + DW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_d = IDLE;
    end
  end

  // State register. Outputs are registered from the next state so the chain
  // sees glitch-free strobes with the same timing as a state decode would give.
  // serial_data_out follows the next shift-register MSB, so it only moves when
  // the shifted word enters SHIFT_LO and is held through SHIFT_HI.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      cfg_addr        <= '0;
      bit_cnt         <= '0;
      div_cnt         <= '0;
      shreg           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cfg_rd          <= 1'b0;
      serial_clock    <= 1'b0;
      serial_data_out <= 1'b0;
      serial_load     <= 1'b0;
    end else begin
      state           <= state_d;
      cfg_addr        <= addr_d;
      bit_cnt         <= bit_cnt_d;
      div_cnt         <= div_cnt_d;
      shreg           <= shreg_d;
      busy            <= (state_d != IDLE);
      done            <= (state_d == DONE);
      cfg_rd          <= (state_d == FETCH);
      serial_clock    <= (state_d == SHIFT_HI);
      serial_load     <= (state_d == LOAD);
      serial_data_out <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && shreg_d[CFG_BITS-1];
    end
  end

endmodule
